// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flip-flop, LSB first.
// Adds two WIDTH-bit operands plus carry-in over WIDTH cycles with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_psum;
    logic [WIDTH-1:0]  r_sum;
    logic [CntW-1:0]   r_cnt;
    logic              r_carry;
    logic              r_cout;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic              w_s;
    logic              w_c;

    // Single full-adder cell working on the operand LSBs.
    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = (r_cnt == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_carry <= cin;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_psum  <= {w_s, r_psum[WIDTH-1:1]};
            r_cnt   <= r_cnt + CntW'(1);
            r_carry <= w_c;
            // Published result only moves on the completion edge.
            if (w_last) begin
                r_sum  <= {w_s, r_psum[WIDTH-1:1]};
                r_cout <= w_c;
            end
        end
    end

    assign busy = (r_state == StRun);
    assign done = (r_state == StDone);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random sweeps at WIDTH 8, 2 and 32,
// all compared every cycle against a cycle-count/arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: an accepted op stays busy for W cycles, then its arithmetic result is published.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [W:0] m_pend = '0;
    logic [W:0] m_res  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_res <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("w8_cycle", 64'({busy, done, cout, sum}), 64'({m_left != 0, m_done, m_res}));
        end
    end

    // Narrow and wide instances under free-running random start/operands.
    for (genvar gi = 0; gi < 2; gi++) begin : g_aux
        localparam int unsigned AW = (gi == 0) ? 2 : 32;
        logic          st;
        logic          ci;
        logic          bz;
        logic          dn;
        logic          co;
        logic [AW-1:0] aa;
        logic [AW-1:0] bb;
        logic [AW-1:0] sm;
        bit            fin = 1'b0;
        int            left = 0;
        logic          mdone = 1'b0;
        logic [AW:0]   pend = '0;
        logic [AW:0]   res = '0;

        serial_adder #(.WIDTH(AW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (st),
            .a     (aa),
            .b     (bb),
            .cin   (ci),
            .busy  (bz),
            .done  (dn),
            .sum   (sm),
            .cout  (co)
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                left  <= 0;
                mdone <= 1'b0;
                res   <= '0;
            end else if (left != 0) begin
                left  <= left - 1;
                mdone <= (left == 1);
                if (left == 1) res <= pend;
            end else begin
                mdone <= 1'b0;
                if (st) begin
                    pend <= {1'b0, aa} + {1'b0, bb} + {{AW{1'b0}}, ci};
                    left <= AW;
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                chk((gi == 0) ? "w2_cycle" : "w32_cycle", 64'({bz, dn, co, sm}),
                    64'({left != 0, mdone, res}));
            end
        end

        initial begin
            st = 1'b0;
            aa = '0;
            bb = '0;
            ci = 1'b0;
            @(posedge rst_n);
            repeat (600) begin
                @(negedge clk);
                st = ($urandom_range(0, 2) != 0);
                aa = AW'($urandom);
                bb = AW'($urandom);
                ci = 1'($urandom);
            end
            @(negedge clk);
            st  = 1'b0;
            fin = 1'b1;
        end
    end

    // Call right after a negedge. k counts negedges from the one that raised start,
    // so a WIDTH-cycle latency shows up as done at k == W+1.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input int pulse_k, output logic [W:0] r, output int lat,
                          output int nbusy);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        cin   = tc;
        r     = '0;
        lat   = 0;
        nbusy = 0;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
            end
            if (k == pulse_k) begin
                start = 1'b1;
                a     = 8'h10;
                b     = 8'h10;
            end
            if (k == pulse_k + 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                r   = {cout, sum};
                break;
            end
        end
    endtask

    logic [W:0]   res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           lat;
    int           nb;
    int           first;
    int           second;
    int           ndone;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_zero", 64'({busy, done, cout, sum}), 64'(0));
        end

        run_op(8'h05, 8'h03, 1'b0, 0, res, lat, nb);
        chk("basic_sum", 64'(res), 64'(9'h008));
        chk("basic_model", 64'(m_res), 64'(9'h008));
        chk("basic_lat", 64'(lat), 64'(W + 1));
        chk("basic_busy", 64'(nb), 64'(W));
        @(negedge clk);

        run_op(8'hFF, 8'h01, 1'b0, 0, res, lat, nb);
        chk("wrap_sum", 64'(res), 64'(9'h100));
        chk("wrap_model", 64'(m_res), 64'(9'h100));
        run_op(8'hFF, 8'hFF, 1'b1, 0, res, lat, nb);
        chk("max_sum", 64'(res), 64'(9'h1FF));
        @(negedge clk);

        run_op(8'h05, 8'h03, 1'b0, 3, res, lat, nb);
        chk("ign_start_sum", 64'(res), 64'(9'h008));
        chk("ign_start_lat", 64'(lat), 64'(W + 1));
        @(negedge clk);

        // Start held high: re-accepted in the done cycle.
        start  = 1'b1;
        a      = 8'h05;
        b      = 8'h03;
        cin    = 1'b0;
        first  = -1;
        second = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        start = 1'b0;
        chk("b2b_first", 64'(first), 64'(W + 1));
        chk("b2b_gap", 64'(second - first), 64'(W + 1));
        repeat (W + 3) @(negedge clk);

        // Reset in the middle of RUN.
        start = 1'b1;
        a     = 8'h21;
        b     = 8'h42;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 64'({busy, done, cout, sum}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_rst", 64'(ndone), 64'(0));
        run_op(8'h7F, 8'h01, 1'b0, 0, res, lat, nb);
        chk("post_rst_sum", 64'(res), 64'(9'h080));

        // Random sweep, sometimes back-to-back from the done cycle.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, 0, res, lat, nb);
            chk("rand_sum", 64'(res), 64'({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}));
            chk("rand_lat", 64'(lat), 64'(W + 1));
        end

        for (int i = 0; i < 5000; i++) begin
            if (g_aux[0].fin && g_aux[1].fin) break;
            @(negedge clk);
        end
        chk("aux_finished", 64'({g_aux[0].fin, g_aux[1].fin}), 64'(2'b11));
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
